muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multicycle integer multiply/divide unit. It replaces the separate fixed-width Mult and Div blocks and their DivMultHigh/DivMultLow muxes in the multicycle CPU.
- Supports signed and unsigned MULT/DIV in one shared shift-add / restoring-divide datapath.
- Drives the High/Low registers directly.
- Uses a start/busy/done handshake towards the control unit.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived from WIDTH).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo are updated
div_zero  output  1  last accepted DIV/DIVU had b=0
hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Reset: one clock with reset=1 forces state=IDLE and busy=0, done=0, div_zero=0, hi=0, lo=0. This applies mid-operation too; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE: when start=1 at edge k:
  - Latch op.
  - Convert a and b to magnitudes for signed ops and record the result signs.
  - Clear the counter and div_zero.
  - Set busy=1 and go to RUN.
  - Exception: DIV/DIVU with b=0 goes directly to FIX with div_zero=1.
- RUN: one bit per cycle, WIDTH iterations (edges k+1..k+WIDTH), then go to FIX.
  - Multiply: add-and-shift on a 2W-bit accumulator.
  - Divide: restoring shift-subtract on remainder and quotient.
- FIX (edge k+WIDTH+1): apply sign correction, write hi/lo, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
  - Total latency is WIDTH+1 cycles from the start edge to the edge where done rises.
- Divide by zero: done rises at edge k+1, div_zero=1, hi/lo keep their previous values. div_zero holds until the next accepted start or reset.
- Signed rules:
  - Product is the exact 2W-bit two's-complement result.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - INT_MIN / -1 gives lo=INT_MIN and hi=0 (wraps, no flag).
- start while busy=1 is ignored: no queueing, and operands are not re-latched.
- a and b need only be valid in the start cycle.
- hi/lo are stable except in the FIX cycle and on reset.
- start is accepted in the cycle after done (back-to-back allowed).

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: a multiply runs only as many RUN iterations as the index of the highest set bit of |b| plus 1, minimum 1. done rises at edge k+iterations+1. Division is unchanged.
- Undefined: every multiply takes exactly WIDTH iterations. No leading-one detect logic is generated.

Decomposition:
- Package muldiv_pkg holds:
  - Enum op_t: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - Enum state_t: IDLE, RUN, FIX.
  - The shared op encoding, so the control unit imports the same constants.
- One sub-module is natural: muldiv_signfix, combinational. It provides abs-value on input and conditional negate of product/quotient/remainder in FIX.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
All scenarios use WIDTH=32.
1. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after the start edge; busy high for 33 cycles.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Immediately follow with DIVU a=7, b=2 -> lo=3, hi=1.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. With hi=0x11, lo=0x22 from a prior op, DIV a=5, b=0 -> done at the edge after start, div_zero=1, hi=0x11, lo=0x22 unchanged. The next accepted start clears div_zero.
5. Start MULT; pulse start again at cycle 5 with different operands -> ignored, result matches the first operands. In a separate op, assert reset at cycle 10 -> next edge busy=0, done=0, hi=lo=0, and no done pulse follows.
6. MULTU a=5, b=3 -> hi=0, lo=15. With MULDIV_EARLY_OUT_EN, done at start+3. Without the macro, done at start+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encoding and FSM states for the multicycle multiply/divide unit.
// The control unit imports this package so that it uses the same op constants.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam int OP_W = 2;

  function automatic logic opIsDiv(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic opIsSigned(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: magnitudes of the incoming operands and
// conditional two's-complement negation of product, quotient and remainder.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               isSigned_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   quot_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic               negLo_i,
  input  logic               negHi_i,
  output logic [WIDTH-1:0]   absA_o,
  output logic [WIDTH-1:0]   absB_o,
  output logic               signA_o,
  output logic               signB_o,
  output logic [2*WIDTH-1:0] prodFix_o,
  output logic [WIDTH-1:0]   quotFix_o,
  output logic [WIDTH-1:0]   remFix_o
);

  always_comb begin
    signA_o   = isSigned_i & a_i[WIDTH-1];
    signB_o   = isSigned_i & b_i[WIDTH-1];
    absA_o    = signA_o ? (~a_i + 1'b1) : a_i;
    absB_o    = signB_o ? (~b_i + 1'b1) : b_i;
    // negLo carries the product sign for multiplies and the quotient sign for divides
    prodFix_o = negLo_i ? (~prod_i + 1'b1) : prod_i;
    quotFix_o = negLo_i ? (~quot_i + 1'b1) : quot_i;
    remFix_o  = negHi_i ? (~rem_i + 1'b1) : rem_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed/unsigned multiply/divide unit driving the High/Low registers.
// Optional macro MULDIV_EARLY_OUT_EN shortens multiplies to the bit length of |b|.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  op_t                op_q, op_d, opIn;
  logic [CNT_W-1:0]   cnt_q, cnt_d, lastIter;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               negHi_q, negHi_d, negLo_q, negLo_d;
  logic               divZero_q, divZero_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   absA, absB;
  logic               signA, signB;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;
  logic [WIDTH:0]     remShift, trialDiff;
  logic               startDivZero;

  assign opIn         = op_t'(op);
  assign startDivZero = opIsDiv(opIn) && (b == '0);

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a_i       (a),
    .b_i       (b),
    .isSigned_i(opIsSigned(opIn)),
    .prod_i    (acc_q),
    .quot_i    (acc_q[WIDTH-1:0]),
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .negLo_i   (negLo_q),
    .negHi_i   (negHi_q),
    .absA_o    (absA),
    .absB_o    (absB),
    .signA_o   (signA),
    .signB_o   (signB),
    .prodFix_o (prodFix),
    .quotFix_o (quotFix),
    .remFix_o  (remFix)
  );

  // Divide keeps {remainder, quotient} in acc; the divisor sits unshifted in mplier.
  assign remShift  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trialDiff = remShift - {1'b0, mplier_q};

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] limit_q, limit_d, leadIter;

  always_comb begin
    leadIter = CNT_W'(1);
    for (int i = 0; i < WIDTH; i++) begin
      if (absB[i]) leadIter = CNT_W'(i + 1);
    end
  end

  assign lastIter = limit_q - CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) limit_q <= CNT_W'(WIDTH);
    else       limit_q <= limit_d;
  end
`else
  assign lastIter = CNT_W'(WIDTH - 1);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = startDivZero ? FIX : RUN;
      RUN:  if (cnt_q == lastIter) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    negHi_d   = negHi_q;
    negLo_d   = negLo_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    limit_d   = limit_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = opIn;
          cnt_d     = '0;
          divZero_d = startDivZero;
          mplier_d  = absB;
          negLo_d   = signA ^ signB;
          if (opIsDiv(opIn)) begin
            acc_d   = {{WIDTH{1'b0}}, absA};
            mcand_d = '0;
            negHi_d = signA;
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, absA};
            negHi_d = signA ^ signB;
          end
`ifdef MULDIV_EARLY_OUT_EN
          limit_d = opIsDiv(opIn) ? CNT_W'(WIDTH) : leadIter;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (opIsDiv(op_q)) begin
          if (!trialDiff[WIDTH]) acc_d = {trialDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        done_d = 1'b1;
        // A divide by zero reports completion but leaves hi/lo untouched
        if (!divZero_q) begin
          hi_d = opIsDiv(op_q) ? remFix  : prodFix[2*WIDTH-1:WIDTH];
          lo_d = opIsDiv(op_q) ? quotFix : prodFix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      negHi_q   <= 1'b0;
      negLo_q   <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      negHi_q   <= negHi_d;
      negLo_q   <= negLo_d;
      divZero_q <= divZero_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign done     = done_q;
  assign div_zero = divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a behavioural model queues expected hi/lo,
// div_zero and latency when an op is driven; each test task pops and compares.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] modelHi = '0, modelLo = '0;
  int          testsRun = 0, testsFailed = 0;
  int          obsLat, obsBusy;
  logic [31:0] obsHi, obsLo;
  logic        obsDz, obsDzStart;

  function automatic exp_t modelOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] mag;
    longint      sx, sy;
    int          msb;
    e.hi = modelHi; e.lo = modelLo; e.dz = 1'b0; e.lat = WIDTH + 1;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    case (o)
      2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (y == 0) begin e.dz = 1'b1; e.lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin e.lo = x; e.hi = '0; end
        else begin e.lo = $signed(x) / $signed(y); e.hi = $signed(x) % $signed(y); end
      end
      default: begin
        if (y == 0) begin e.dz = 1'b1; e.lat = 1; end
        else begin e.lo = x / y; e.hi = x % y; end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o == 2'b00 && y[31]) ? -y : y;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      e.lat = msb + 2;
    end
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = modelOp(o, x, y);
    sbQ.push_back(e);
    modelHi = e.hi; modelLo = e.lo;
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    obsDzStart = div_zero; obsBusy = 0; obsLat = 0;
    while (done !== 1'b1 && obsLat < 100) begin
      if (busy === 1'b1) obsBusy++;
      @(posedge clock); #1;
      obsLat++;
    end
    obsHi = hi; obsLo = lo; obsDz = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    testsRun++;
    if ({busy, done, div_zero} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
    testsRun++;
    if ({hi, lo} !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_hilo got %h want 0", {hi, lo}); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    exp_t e;
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {e.hi, e.lo} || {e.hi, e.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin testsFailed++; $display("[TB] FAIL mult_signed got %h want %h", {obsHi, obsLo}, {e.hi, e.lo}); end
    testsRun++;
    if (obsLat !== e.lat) begin testsFailed++; $display("[TB] FAIL mult_latency got %0d want %0d", obsLat, e.lat); end
    testsRun++;
    if (obsBusy !== e.lat) begin testsFailed++; $display("[TB] FAIL mult_busy_cycles got %0d want %0d", obsBusy, e.lat); end
    @(posedge clock); #1;
    testsRun++;
    if ({done, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL done_pulse_width got %b want 00", {done, busy}); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {e.hi, e.lo} || {e.hi, e.lo} !== 64'hFFFF_FFFE_0000_0001) begin testsFailed++; $display("[TB] FAIL multu_max got %h want %h", {obsHi, obsLo}, {e.hi, e.lo}); end
    applyStimulus(2'b11, 32'd7, 32'd2);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {32'd1, 32'd3}) begin testsFailed++; $display("[TB] FAIL divu_b2b got %h want %h", {obsHi, obsLo}, {32'd1, 32'd3}); end
    testsRun++;
    if (obsLat !== e.lat) begin testsFailed++; $display("[TB] FAIL divu_latency got %0d want %0d", obsLat, e.lat); end
  endtask

  task automatic test_div_signed();
    exp_t e;
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {e.hi, e.lo} || {e.hi, e.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin testsFailed++; $display("[TB] FAIL div_neg got %h want %h", {obsHi, obsLo}, {e.hi, e.lo}); end
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== 64'h0000_0000_8000_0000) begin testsFailed++; $display("[TB] FAIL div_intmin got %h want %h", {obsHi, obsLo}, 64'h0000_0000_8000_0000); end
    testsRun++;
    if (obsDz !== 1'b0) begin testsFailed++; $display("[TB] FAIL div_intmin_flag got %b want 0", obsDz); end
  endtask

  task automatic test_div_zero();
    exp_t e;
    applyStimulus(2'b11, 32'h451, 32'h20);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {32'h11, 32'h22}) begin testsFailed++; $display("[TB] FAIL divz_setup got %h want %h", {obsHi, obsLo}, {32'h11, 32'h22}); end
    applyStimulus(2'b10, 32'd5, 32'd0);
    e = sbQ.pop_front();
    testsRun++;
    if (obsLat !== 1) begin testsFailed++; $display("[TB] FAIL divz_latency got %0d want 1", obsLat); end
    testsRun++;
    if (obsDz !== e.dz || obsDz !== 1'b1) begin testsFailed++; $display("[TB] FAIL divz_flag got %b want 1", obsDz); end
    testsRun++;
    if ({obsHi, obsLo} !== {32'h11, 32'h22}) begin testsFailed++; $display("[TB] FAIL divz_hold got %h want %h", {obsHi, obsLo}, {32'h11, 32'h22}); end
    applyStimulus(2'b01, 32'd2, 32'd3);
    e = sbQ.pop_front();
    testsRun++;
    if (obsDzStart !== 1'b0) begin testsFailed++; $display("[TB] FAIL divz_clear got %b want 0", obsDzStart); end
    testsRun++;
    if (obsLo !== e.lo) begin testsFailed++; $display("[TB] FAIL divz_next_op got %h want %h", obsLo, e.lo); end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    e = modelOp(2'b00, 32'd1234, 32'hFFFF_FF00);
    sbQ.push_back(e);
    modelHi = e.hi; modelLo = e.lo;
    @(negedge clock);
    op = 2'b00; a = 32'd1234; b = 32'hFFFF_FF00; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    obsLat = 0;
    while (done !== 1'b1 && obsLat < 100) begin
      @(negedge clock);
      start = (obsLat == 4);
      if (obsLat == 4) begin op = 2'b01; a = 32'd99; b = 32'd77; end
      @(posedge clock); #1;
      obsLat++;
    end
    start = 1'b0;
    e = sbQ.pop_front();
    testsRun++;
    if ({hi, lo} !== {e.hi, e.lo}) begin testsFailed++; $display("[TB] FAIL start_ignored got %h want %h", {hi, lo}, {e.hi, e.lo}); end
    testsRun++;
    if (obsLat !== e.lat) begin testsFailed++; $display("[TB] FAIL start_ignored_lat got %0d want %0d", obsLat, e.lat); end
  endtask

  task automatic test_reset_mid_op();
    int doneSeen;
    @(negedge clock);
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    testsRun++;
    if ({busy, done, hi, lo} !== 66'h0) begin testsFailed++; $display("[TB] FAIL reset_mid_op got %h want 0", {busy, done, hi, lo}); end
    @(negedge clock); reset = 1'b0;
    modelHi = '0; modelLo = '0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) doneSeen++;
    end
    testsRun++;
    if (doneSeen !== 0) begin testsFailed++; $display("[TB] FAIL reset_no_done got %0d want 0", doneSeen); end
  endtask

  task automatic test_early_out();
    exp_t e;
    applyStimulus(2'b01, 32'd5, 32'd3);
    e = sbQ.pop_front();
    testsRun++;
    if ({obsHi, obsLo} !== {32'd0, 32'd15}) begin testsFailed++; $display("[TB] FAIL multu_small got %h want %h", {obsHi, obsLo}, {32'd0, 32'd15}); end
    testsRun++;
    if (obsLat !== e.lat) begin testsFailed++; $display("[TB] FAIL multu_small_lat got %0d want %0d", obsLat, e.lat); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(0, 300)) : $urandom);
      if (i % 3 == 0) x = -x;
      applyStimulus(o, x, y);
      e = sbQ.pop_front();
      testsRun++;
      if ({obsHi, obsLo, obsDz} !== {e.hi, e.lo, e.dz} || obsLat !== e.lat) begin
        testsFailed++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h got %h/%h dz=%b lat=%0d want %h/%h dz=%b lat=%0d",
                 i, o, x, y, obsHi, obsLo, obsDz, obsLat, e.hi, e.lo, e.dz, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_early_out();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
